// File: rtl/alu_pkg.sv
// Shared opcode encoding and width constants for the RV32I execute-stage ALU.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SLTU  = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_NOR   = 4'b1010,
        ALU_PASSB = 4'b1011,
        ALU_ANDN  = 4'b1100,
        ALU_ORN   = 4'b1101,
        ALU_XNOR  = 4'b1110,
        ALU_PASSA = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_v_32_core.sv
// Combinational datapath: result plus ADD/SUB carry and signed-overflow flags.
module alu_v_32_core
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            overflow_o,
    output logic            cout_o
);

    logic            is_sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [SHAMT_W-1:0] shamt;
    logic            add_ov;

    // One shared 33-bit adder; SUB is A + ~B + 1 so bit 32 is the no-borrow flag.
    assign is_sub = (op_i == ALU_SUB);
    assign b_eff  = is_sub ? ~b_i : b_i;
    assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    assign shamt  = b_i[SHAMT_W-1:0];
    assign add_ov = (a_i[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        cout_o     = 1'b0;
        case (op_i)
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_ADD: begin
                result_o   = sum[XLEN-1:0];
                overflow_o = add_ov;
                cout_o     = sum[XLEN];
            end
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SLL:   result_o = a_i << shamt;
            ALU_SRL:   result_o = a_i >> shamt;
            ALU_SUB: begin
                result_o   = sum[XLEN-1:0];
                overflow_o = add_ov;
                cout_o     = sum[XLEN];
            end
            ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_NOR:   result_o = ~(a_i | b_i);
            ALU_PASSB: result_o = b_i;
            ALU_ANDN:  result_o = a_i & ~b_i;
            ALU_ORN:   result_o = a_i | ~b_i;
            ALU_XNOR:  result_o = ~(a_i ^ b_i);
            ALU_PASSA: result_o = a_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_v_32.sv
// Registered 32-bit ALU: core datapath followed by one output register stage.
module alu_v_32
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUCtl,
    output logic            zero,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            cout
);

    logic [XLEN-1:0] result_d, result_q;
    logic            overflow_d, overflow_q;
    logic            cout_d, cout_q;
    logic            zero_d, zero_q;

    alu_v_32_core u_core (
        .a_i        (A),
        .b_i        (B),
        .op_i       (ALUCtl),
        .result_o   (result_d),
        .overflow_o (overflow_d),
        .cout_o     (cout_d)
    );

    // Zero flag tracks the value being registered, not the operands.
    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            cout_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            cout_q     <= cout_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign cout     = cout_q;

endmodule

// File: tb/tb_alu_v_32.sv
// Directed-vector bench for alu_v_32: opcode sweeps, flag corners, reset and throughput.
module tb_alu_v_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALUCtl = '0;
    logic        zero;
    logic [31:0] result;
    logic        overflow;
    logic        cout;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        co;
        string       name;
    } vec_t;

    vec_t vecs[$];

    alu_v_32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .ALUCtl   (ALUCtl),
        .zero     (zero),
        .result   (result),
        .overflow (overflow),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    task automatic addv(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] res, input logic ov, input logic co, input string name);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res;
        v.z = (res == 32'd0); v.ov = ov; v.co = co; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] r, input logic z,
                         input logic ov, input logic co);
        n_vec++;
        if (result !== r || zero !== z || overflow !== ov || cout !== co) begin
            n_bad++;
            $display("FAIL %s: got res=%h z=%b ov=%b co=%b, want res=%h z=%b ov=%b co=%b",
                     name, result, zero, overflow, cout, r, z, ov, co);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        A = a; B = b; ALUCtl = op;
    endtask

    initial begin
        // A=100, B=40 full sweep
        addv(100, 40, 4'h0, 32'd32,        0, 0, "and_100_40");
        addv(100, 40, 4'h1, 32'd108,       0, 0, "or_100_40");
        addv(100, 40, 4'h2, 32'd140,       0, 0, "add_100_40");
        addv(100, 40, 4'h3, 32'd76,        0, 0, "xor_100_40");
        addv(100, 40, 4'h4, 32'd25600,     0, 0, "sll_100_40");
        addv(100, 40, 4'h5, 32'd0,         0, 0, "srl_100_40");
        addv(100, 40, 4'h6, 32'd60,        0, 1, "sub_100_40");
        addv(100, 40, 4'h7, 32'd0,         0, 0, "slt_100_40");
        addv(100, 40, 4'h8, 32'd0,         0, 0, "sltu_100_40");
        addv(100, 40, 4'h9, 32'd0,         0, 0, "sra_100_40");
        addv(100, 40, 4'hA, 32'hFFFFFF93,  0, 0, "nor_100_40");
        addv(100, 40, 4'hB, 32'd40,        0, 0, "passb_100_40");
        addv(100, 40, 4'hC, 32'd68,        0, 0, "andn_100_40");
        addv(100, 40, 4'hD, 32'hFFFFFFF7,  0, 0, "orn_100_40");
        addv(100, 40, 4'hE, 32'hFFFFFFB3,  0, 0, "xnor_100_40");
        addv(100, 40, 4'hF, 32'd100,       0, 0, "passa_100_40");
        // negative operands
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h2, 32'hFFFFFFFD, 0, 1, "add_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h6, 32'hFFFFFFFF, 0, 0, "sub_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h7, 32'd1,        0, 0, "slt_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h8, 32'd1,        0, 0, "sltu_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h9, 32'hFFFFFFFF, 0, 0, "sra_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h5, 32'd1,        0, 0, "srl_neg");
        addv(32'hFFFFFFFE, 32'hFFFFFFFF, 4'h0, 32'hFFFFFFFE, 0, 0, "and_neg");
        // signed overflow
        addv(32'h7FFFFFFF, 32'd1, 4'h2, 32'h80000000, 1, 0, "add_ovf");
        addv(32'h80000000, 32'd1, 4'h6, 32'h7FFFFFFF, 1, 1, "sub_ovf");
        // zero results and shift amount masking (B[31:5] ignored)
        addv(32'h12345678, 32'h12345678, 4'h6, 32'd0, 0, 1, "sub_eq");
        addv(32'h12345678, 32'h12345678, 4'h3, 32'd0, 0, 0, "xor_eq");
        addv(32'h00000001, 32'hFFFFFFE4, 4'h4, 32'h00000010, 0, 0, "sll_mask");
        addv(32'h80000000, 32'h00000021, 4'h9, 32'hC0000000, 0, 0, "sra_mask");

        // reset state while held
        #12;
        check("reset_hold", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].ov, vecs[i].co);
        end

        // inputs changing between edges must not disturb the registered output
        drive(100, 40, 4'h2);
        @(posedge clk); #1;
        A = 32'h7FFFFFFF; B = 32'd1; ALUCtl = 4'h6;
        #2;
        check("hold_between_edges", 32'd140, 1'b0, 1'b0, 1'b0);

        // async reset mid-cycle while result=140
        @(posedge clk); #1;
        drive(100, 40, 4'h2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held_edge", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        A = 100; B = 40; ALUCtl = 4'h6;
        @(posedge clk); #1;
        check("first_after_reset", 32'd60, 1'b0, 1'b0, 1'b1);

        // back-to-back issue: ADD, SUB, AND with no bubbles
        drive(100, 40, 4'h2);
        @(posedge clk); #1;
        check("tput_add", 32'd140, 1'b0, 1'b0, 1'b0);
        drive(100, 40, 4'h6);
        @(posedge clk); #1;
        check("tput_sub", 32'd60, 1'b0, 1'b0, 1'b1);
        drive(100, 40, 4'h0);
        @(posedge clk); #1;
        check("tput_and", 32'd32, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
